// File: rtl/dma_pkg.sv
// Shared register map, CTRL/STATUS bit positions, FSM encoding and config bundle for dma_mem_engine.
// No logic; imported by dma_io_regs and dma_mem_engine.
package dma_pkg;

    localparam logic [13:0] REG_CTRL = 14'd0;
    localparam logic [13:0] REG_ADDR = 14'd1;
    localparam logic [13:0] REG_LEN  = 14'd2;
    localparam logic [13:0] REG_STAT = 14'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_ABORT   = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_REM_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_OUT     = 3'd3,
        ST_IN      = 3'd4,
        ST_WR      = 3'd5
    } dma_state_t;

    typedef struct packed {
        logic        dir;
        logic [13:0] addr;
        logic [15:0] len;
    } dma_cfg_t;

endpackage

// File: rtl/dma_io_regs.sv
// DMA IO-space registers: decode, W1/W1C, read mux; rdata one cycle after radr. Optional DMA_IRQ_EN adds the irq flop.
// Never backpressures the CPU; ADDR/LEN/DIR writes and START are dropped while busy.
module dma_io_regs
    import dma_pkg::*;
#(
    parameter logic [13:0] REG_BASE = 14'h3C00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_we,
    input  logic [13:0] io_wadr,
    input  logic [31:0] io_wdata,
    input  logic [13:0] io_radr,
    output logic [31:0] io_rdata,
    input  logic        busy,
    input  logic        done_set,
    input  logic [15:0] rem,
    output logic        start,
    output logic        abort,
    output dma_cfg_t    cfg,
    output logic        irq
);

    logic [13:0] woff, roff;
    logic        wr_ctrl, wr_addr, wr_len, wr_stat;
    logic        dir_q, done_q, aborted_q, irq_en;
    logic [13:0] addr_q;
    logic [15:0] len_q;
    logic [31:0] rd_next, rdata_q;
    logic        unused_wdata;

    assign woff    = io_wadr - REG_BASE;
    assign roff    = io_radr - REG_BASE;
    assign wr_ctrl = io_we && (woff == REG_CTRL);
    assign wr_addr = io_we && (woff == REG_ADDR);
    assign wr_len  = io_we && (woff == REG_LEN);
    assign wr_stat = io_we && (woff == REG_STAT);

    assign start = wr_ctrl && io_wdata[CTRL_START] && !busy;
    assign abort = wr_ctrl && io_wdata[CTRL_ABORT];

    // DIR is bypassed so a single CTRL write can set the direction and start
    assign cfg.dir  = (wr_ctrl && !busy) ? io_wdata[CTRL_DIR] : dir_q;
    assign cfg.addr = addr_q;
    assign cfg.len  = len_q;

    assign unused_wdata = ^io_wdata[31:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr_ctrl && !busy) dir_q  <= io_wdata[CTRL_DIR];
            if (wr_addr && !busy) addr_q <= io_wdata[15:2];
            if (wr_len  && !busy) len_q  <= io_wdata[15:0];
            if (done_set)
                done_q <= 1'b1;
            else if (wr_stat && io_wdata[STAT_DONE])
                done_q <= 1'b0;
            if (abort)
                aborted_q <= 1'b1;
            else if (wr_stat && io_wdata[STAT_ABORTED])
                aborted_q <= 1'b0;
            rdata_q <= rd_next;
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= io_wdata[CTRL_IRQ_EN];
            irq_q <= done_q && irq_en_q;
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        case (roff)
            REG_CTRL: begin
                rd_next[CTRL_DIR]    = dir_q;
                rd_next[CTRL_IRQ_EN] = irq_en;
            end
            REG_ADDR: rd_next[15:2] = addr_q;
            REG_LEN:  rd_next[15:0] = len_q;
            REG_STAT: begin
                rd_next[STAT_BUSY]             = busy;
                rd_next[STAT_DONE]             = done_q;
                rd_next[STAT_ABORTED]          = aborted_q;
                rd_next[STAT_REM_LSB +: 16]    = rem;
            end
            default: rd_next = '0;
        endcase
    end

    assign io_rdata = rdata_q;

endmodule

// File: rtl/dma_mem_engine.sv
// DMA engine: data RAM <-> 16-bit valid/ready stream; 3 cycles/item mem->stream, 2 cycles/item stream->mem. Macro DMA_IRQ_EN.
// Requests wait out mem_hold; so_valid holds until so_ready; si_ready only while waiting for an item.
module dma_mem_engine
    import dma_pkg::*;
#(
    parameter logic [13:0] REG_BASE = 14'h3C00,
    parameter int          AWIDTH   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dma_io_we,
    input  logic [13:0]       dma_io_wadr,
    input  logic [31:0]       dma_io_wdata,
    input  logic [13:0]       dma_io_radr,
    output logic [31:0]       dma_io_rdata,
    input  logic              mem_hold,
    output logic              dma_we_ma,
    output logic [AWIDTH-1:0] dataram_wadr_ma,
    output logic [15:0]       dataram_wdata_ma,
    output logic              dma_re_ma,
    output logic [AWIDTH-1:0] dataram_radr_ma,
    input  logic [15:0]       dataram_rdata_wb,
    output logic              so_valid,
    output logic [15:0]       so_data,
    input  logic              so_ready,
    input  logic              si_valid,
    input  logic [15:0]       si_data,
    output logic              si_ready,
    output logic              dma_busy,
    output logic              dma_irq
);

    dma_state_t        state, nstate;
    dma_cfg_t          cfg;
    logic              start, abort, done_set;
    logic              load, advance, cap_out, cap_in;
    logic [AWIDTH-1:0] cur_addr, radr_hold, wadr_hold;
    logic [15:0]       rem, obuf, ibuf, wdata_hold;

    dma_io_regs #(.REG_BASE(REG_BASE)) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_we    (dma_io_we),
        .io_wadr  (dma_io_wadr),
        .io_wdata (dma_io_wdata),
        .io_radr  (dma_io_radr),
        .io_rdata (dma_io_rdata),
        .busy     (dma_busy),
        .done_set (done_set),
        .rem      (rem),
        .start    (start),
        .abort    (abort),
        .cfg      (cfg),
        .irq      (dma_irq)
    );

    assign dma_busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            rem        <= '0;
            obuf       <= '0;
            ibuf       <= '0;
            radr_hold  <= '0;
            wadr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            state <= nstate;
            if (load) begin
                cur_addr <= AWIDTH'(cfg.addr);
                rem      <= cfg.len;
            end else if (advance) begin
                cur_addr <= cur_addr + AWIDTH'(1);
                rem      <= rem - 16'd1;
            end
            if (cap_out) obuf <= dataram_rdata_wb;
            if (cap_in)  ibuf <= si_data;
            if (dma_re_ma) radr_hold <= cur_addr;
            if (dma_we_ma) begin
                wadr_hold  <= cur_addr;
                wdata_hold <= ibuf;
            end
        end
    end

    // Abort overrides every state so no strobe or handshake can leak out that cycle
    always_comb begin
        nstate    = state;
        load      = 1'b0;
        advance   = 1'b0;
        cap_out   = 1'b0;
        cap_in    = 1'b0;
        done_set  = 1'b0;
        dma_re_ma = 1'b0;
        dma_we_ma = 1'b0;
        so_valid  = 1'b0;
        si_ready  = 1'b0;
        if (abort) begin
            nstate = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        load = 1'b1;
                        if (cfg.len == '0)
                            done_set = 1'b1;
                        else
                            nstate = cfg.dir ? ST_IN : ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (!mem_hold) begin
                        dma_re_ma = 1'b1;
                        nstate    = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    cap_out = 1'b1;
                    nstate  = ST_OUT;
                end
                ST_OUT: begin
                    so_valid = 1'b1;
                    if (so_ready) begin
                        advance = 1'b1;
                        if (rem == 16'd1) begin
                            done_set = 1'b1;
                            nstate   = ST_IDLE;
                        end else begin
                            nstate = ST_RD_REQ;
                        end
                    end
                end
                ST_IN: begin
                    si_ready = 1'b1;
                    if (si_valid) begin
                        cap_in = 1'b1;
                        nstate = ST_WR;
                    end
                end
                ST_WR: begin
                    if (!mem_hold) begin
                        dma_we_ma = 1'b1;
                        advance   = 1'b1;
                        if (rem == 16'd1) begin
                            done_set = 1'b1;
                            nstate   = ST_IDLE;
                        end else begin
                            nstate = ST_IN;
                        end
                    end
                end
                default: nstate = ST_IDLE;
            endcase
        end
    end

    assign so_data          = obuf;
    assign dataram_radr_ma  = dma_re_ma ? cur_addr : radr_hold;
    assign dataram_wadr_ma  = dma_we_ma ? cur_addr : wadr_hold;
    assign dataram_wdata_ma = dma_we_ma ? ibuf : wdata_hold;

endmodule

// File: tb/tb_dma_mem_engine.sv
// Bench for dma_mem_engine: transaction-level reference model checked every cycle, directed cases plus randomized transfers.
module tb_dma_mem_engine;
    import dma_pkg::*;

    localparam logic [13:0] BASE = 14'h3C00;

    logic        clk, rst_n;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr, dma_io_radr;
    logic [31:0] dma_io_wdata, dma_io_rdata;
    logic        mem_hold;
    logic        dma_we_ma, dma_re_ma;
    logic [13:0] dataram_wadr_ma, dataram_radr_ma;
    logic [15:0] dataram_wdata_ma, dataram_rdata_wb;
    logic        so_valid, so_ready, si_valid, si_ready;
    logic [15:0] so_data, si_data;
    logic        dma_busy, dma_irq;

    dma_mem_engine #(.REG_BASE(BASE), .AWIDTH(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
        .dma_io_radr(dma_io_radr), .dma_io_rdata(dma_io_rdata),
        .mem_hold(mem_hold),
        .dma_we_ma(dma_we_ma), .dataram_wadr_ma(dataram_wadr_ma), .dataram_wdata_ma(dataram_wdata_ma),
        .dma_re_ma(dma_re_ma), .dataram_radr_ma(dataram_radr_ma), .dataram_rdata_wb(dataram_rdata_wb),
        .so_valid(so_valid), .so_data(so_data), .so_ready(so_ready),
        .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready),
        .dma_busy(dma_busy), .dma_irq(dma_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] ram     [0:16383];
    logic [15:0] ref_mem [0:16383];

    // reference model of the programmer-visible state
    logic        m_busy, m_dir, m_irqen, m_done, m_aborted, m_irq, m_have_in;
    logic [13:0] m_addr, m_cur;
    logic [15:0] m_len, m_rem, m_in;
    int          m_reads;
    logic [31:0] exp_rd;
    logic        prev_wait, chk_en;
    logic [15:0] prev_so;
    logic [15:0] so_log[$];
    logic [13:0] wr_adr_log[$];
    logic [15:0] wr_dat_log[$];

    // stimulus knobs
    logic [15:0] si_q[$];
    int          so_mode, so_pct, si_pct, hold_pct;
    logic        hold_manual;

    function automatic logic [31:0] model_rd(input logic [13:0] a);
        logic [13:0] o;
        logic [31:0] r;
        o = a - BASE;
        r = '0;
        case (o)
            REG_CTRL: begin r[CTRL_DIR] = m_dir; r[CTRL_IRQ_EN] = m_irqen; end
            REG_ADDR: r[15:2] = m_addr;
            REG_LEN:  r[15:0] = m_len;
            REG_STAT: r = {m_rem, 13'd0, m_aborted, m_done, m_busy};
            default:  r = '0;
        endcase
        return r;
    endfunction

    logic [13:0] c_wo;
    logic        c_abort, c_done_hw, c_busy_pre;

    always @(negedge clk) begin
        if (chk_en) begin
            c_wo    = dma_io_wadr - BASE;
            c_abort = dma_io_we && (c_wo == REG_CTRL) && dma_io_wdata[CTRL_ABORT];
            check("busy", dma_busy, m_busy);
            check("rdata", dma_io_rdata, exp_rd);
            check("irq", dma_irq, m_irq);
            if (mem_hold) check("hold_no_req", {dma_re_ma, dma_we_ma}, 0);
            if (!m_busy) check("idle_quiet", {dma_re_ma, dma_we_ma, so_valid, si_ready}, 0);
            if (m_busy) check("dir_quiet", m_dir ? {dma_re_ma, so_valid} : {dma_we_ma, si_ready}, 0);
            if (prev_wait && !c_abort) check("so_stable", {so_valid, so_data}, {1'b1, prev_so});
            prev_wait = so_valid && !so_ready;
            prev_so   = so_data;

            exp_rd     = model_rd(dma_io_radr);
            m_irq      = m_done && m_irqen;
            c_done_hw  = 1'b0;
            c_busy_pre = m_busy;

            if (dma_re_ma) begin
                check("rd_addr", dataram_radr_ma, m_cur);
                m_reads++;
            end
            if (so_valid && so_ready) begin
                check("so_data", so_data, ref_mem[m_cur]);
                check("reads_per_item", m_reads, 1);
                so_log.push_back(so_data);
                m_reads = 0;
                m_cur++; m_rem--;
                if (m_rem == 0) begin m_busy = 0; c_done_hw = 1; end
            end
            if (si_valid && si_ready) begin
                check("si_once", m_have_in, 0);
                m_in = si_data;
                m_have_in = 1;
            end
            if (dma_we_ma) begin
                check("wr_addr", dataram_wadr_ma, m_cur);
                check("wr_data", dataram_wdata_ma, m_in);
                check("wr_has_data", m_have_in, 1);
                ref_mem[m_cur] = m_in;
                wr_adr_log.push_back(dataram_wadr_ma);
                wr_dat_log.push_back(dataram_wdata_ma);
                m_have_in = 0;
                m_cur++; m_rem--;
                if (m_rem == 0) begin m_busy = 0; c_done_hw = 1; end
            end

            if (dma_io_we) begin
                case (c_wo)
                    REG_CTRL: begin
                        if (!c_busy_pre) m_dir = dma_io_wdata[CTRL_DIR];
`ifdef DMA_IRQ_EN
                        m_irqen = dma_io_wdata[CTRL_IRQ_EN];
`endif
                        if (dma_io_wdata[CTRL_ABORT]) begin
                            m_busy = 0; m_aborted = 1; m_have_in = 0; m_reads = 0;
                        end else if (dma_io_wdata[CTRL_START] && !c_busy_pre) begin
                            m_cur = m_addr; m_rem = m_len;
                            if (m_len == 0) c_done_hw = 1; else m_busy = 1;
                        end
                    end
                    REG_ADDR: if (!c_busy_pre) m_addr = dma_io_wdata[15:2];
                    REG_LEN:  if (!c_busy_pre) m_len = dma_io_wdata[15:0];
                    REG_STAT: begin
                        if (dma_io_wdata[STAT_DONE])    m_done = 0;
                        if (dma_io_wdata[STAT_ABORTED]) m_aborted = 0;
                    end
                    default: ;
                endcase
            end
            if (c_done_hw) m_done = 1;
        end
    end

    // data-RAM slave: read data one cycle after dma_re_ma
    logic        r_re, r_we;
    logic [13:0] r_ra, r_wa;
    logic [15:0] r_wd;
    initial begin
        forever begin
            @(negedge clk);
            r_re = dma_re_ma; r_ra = dataram_radr_ma;
            r_we = dma_we_ma; r_wa = dataram_wadr_ma; r_wd = dataram_wdata_ma;
            @(posedge clk);
            #1;
            if (r_re) dataram_rdata_wb = ram[r_ra];
            if (r_we) ram[r_wa] = r_wd;
        end
    end

    // stream / hold driver
    logic d_hs;
    initial begin
        forever begin
            @(negedge clk);
            d_hs = si_valid && si_ready;
            @(posedge clk);
            #1;
            if (d_hs && si_q.size() > 0) void'(si_q.pop_front());
            if (so_mode == 1) so_ready = ~so_ready;
            else if (so_mode == 0) so_ready = ($urandom_range(99) < so_pct);
            if (!hold_manual) mem_hold = ($urandom_range(99) < hold_pct);
            si_valid = (si_q.size() > 0) && ($urandom_range(99) < si_pct);
            si_data  = (si_q.size() > 0) ? si_q[0] : 16'($urandom);
        end
    end

    task automatic wr_reg(input logic [13:0] off, input logic [31:0] d);
        @(posedge clk); #1;
        dma_io_we = 1; dma_io_wadr = BASE + off; dma_io_wdata = d;
        @(posedge clk); #1;
        dma_io_we = 0;
    endtask

    task automatic rd_reg(input logic [13:0] off, output logic [31:0] v);
        @(posedge clk); #1;
        dma_io_radr = BASE + off;
        @(posedge clk);
        @(negedge clk);
        v = dma_io_rdata;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((dma_busy || m_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_budget", n < budget, 1);
        if (n >= budget) wr_reg(REG_CTRL, 32'h8);
    endtask

    task automatic wait_si_hs(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(si_valid && si_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("si_hs_in_budget", n < budget, 1);
    endtask

    logic [31:0] v;
    logic [15:0] rv;
    int          len, n;

    initial begin
        rst_n = 0; dma_io_we = 0; dma_io_wadr = '0; dma_io_wdata = '0; dma_io_radr = '0;
        mem_hold = 0; dataram_rdata_wb = '0; so_ready = 0; si_valid = 0; si_data = '0;
        so_mode = 0; so_pct = 100; si_pct = 100; hold_pct = 0; hold_manual = 0;
        m_busy = 0; m_dir = 0; m_irqen = 0; m_done = 0; m_aborted = 0; m_irq = 0; m_have_in = 0;
        m_addr = '0; m_cur = '0; m_len = '0; m_rem = '0; m_in = '0; m_reads = 0;
        exp_rd = '0; prev_wait = 0; prev_so = '0; chk_en = 0;
        for (int i = 0; i < 16384; i++) begin
            rv = 16'($urandom);
            ram[i] = rv; ref_mem[i] = rv;
        end
        ram[14'h40] = 16'h1111; ram[14'h41] = 16'h2222; ram[14'h42] = 16'h3333;
        ref_mem[14'h40] = 16'h1111; ref_mem[14'h41] = 16'h2222; ref_mem[14'h42] = 16'h3333;

        repeat (3) @(negedge clk);
        check("reset_rdata", dma_io_rdata, 0);
        check("reset_strobes", {dma_busy, dma_re_ma, dma_we_ma, so_valid, si_ready, dma_irq}, 0);
        check("reset_data_outs", {so_data, dataram_wdata_ma}, 0);
        check("reset_addr_outs", {dataram_radr_ma, dataram_wadr_ma}, 0);
        @(posedge clk); #1;
        rst_n = 1; chk_en = 1;

        // register readback
        wr_reg(REG_ADDR, 32'h0000_0100);
        wr_reg(REG_LEN, 32'h0000_0003);
        rd_reg(REG_ADDR, v); check("rd_addr_lit", v, 32'h0000_0100);
        rd_reg(REG_LEN, v);  check("rd_len_lit", v, 32'h0000_0003);
        rd_reg(14'd5, v);    check("rd_unmapped_lit", v, 32'h0);

        // mem->stream, so_ready toggling
        so_mode = 1; so_log.delete();
        wr_reg(REG_CTRL, 32'h1);
        wait_idle(200);
        check("m2s_count", so_log.size(), 3);
        if (so_log.size() == 3) begin
            check("m2s_item0", so_log[0], 16'h1111);
            check("m2s_item1", so_log[1], 16'h2222);
            check("m2s_item2", so_log[2], 16'h3333);
        end
        rd_reg(REG_STAT, v); check("m2s_status_lit", v, 32'h0000_0002);

        // stream->mem
        so_mode = 0; so_pct = 100;
        wr_reg(REG_STAT, 32'h2);
        wr_reg(REG_ADDR, 32'h0000_0200);
        wr_reg(REG_LEN, 32'h2);
        si_q.delete(); si_q.push_back(16'hAAAA); si_q.push_back(16'hBBBB);
        wr_adr_log.delete(); wr_dat_log.delete();
        wr_reg(REG_CTRL, 32'h3);
        wait_idle(200);
        check("s2m_count", wr_adr_log.size(), 2);
        if (wr_adr_log.size() == 2) begin
            check("s2m_adr0", wr_adr_log[0], 14'h80);
            check("s2m_adr1", wr_adr_log[1], 14'h81);
            check("s2m_dat0", wr_dat_log[0], 16'hAAAA);
            check("s2m_dat1", wr_dat_log[1], 16'hBBBB);
        end
        check("s2m_ram", {ram[14'h80], ram[14'h81]}, 32'hAAAA_BBBB);
        rd_reg(REG_STAT, v); check("s2m_status_lit", v, 32'h0000_0002);

        // mem_hold during RD_REQ
        wr_reg(REG_STAT, 32'h2);
        wr_reg(REG_ADDR, 32'h0000_0100);
        wr_reg(REG_LEN, 32'h1);
        hold_manual = 1;
        @(posedge clk); #1; mem_hold = 1;
        wr_reg(REG_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        #1 mem_hold = 0;
        @(negedge clk);
        check("hold_release_re", dma_re_ma, 1);
        check("hold_release_radr", dataram_radr_ma, 14'h40);
        wait_idle(100);
        check("hold_rd_item", so_log[$], 16'h1111);

        // mem_hold during WR
        wr_reg(REG_STAT, 32'h2);
        wr_reg(REG_ADDR, 32'h0000_0300);
        si_q.delete(); si_q.push_back(16'h1234);
        @(posedge clk); #1; mem_hold = 1;
        wr_reg(REG_CTRL, 32'h3);
        wait_si_hs(50);
        repeat (5) @(posedge clk);
        #1 mem_hold = 0;
        @(negedge clk);
        check("hold_release_we", dma_we_ma, 1);
        check("hold_release_wadr", dataram_wadr_ma, 14'hC0);
        check("hold_release_wdata", dataram_wdata_ma, 16'h1234);
        wait_idle(100);
        hold_manual = 0;

        // LEN=0
        wr_reg(REG_STAT, 32'h2);
        wr_reg(REG_LEN, 32'h0);
        wr_reg(REG_CTRL, 32'h1);
        rd_reg(REG_STAT, v); check("len0_status_lit", v, 32'h0000_0002);

        // START while busy, then ABORT after item 1 of 4
        wr_reg(REG_STAT, 32'h2);
        wr_reg(REG_ADDR, 32'h0000_0100);
        wr_reg(REG_LEN, 32'h4);
        so_mode = 2; so_ready = 0;
        wr_reg(REG_CTRL, 32'h1);
        repeat (5) @(posedge clk);
        wr_reg(REG_ADDR, 32'h0000_0900);
        wr_reg(REG_CTRL, 32'h1);
        rd_reg(REG_STAT, v); check("busy_start_status_lit", v, 32'h0004_0001);
        rd_reg(REG_ADDR, v); check("busy_addr_kept_lit", v, 32'h0000_0100);
        @(posedge clk); #1 so_ready = 1;
        n = 0;
        @(negedge clk);
        while (!(so_valid && so_ready) && n < 50) begin @(negedge clk); n++; end
        check("abort_item1_seen", n < 50, 1);
        @(posedge clk); #1 so_ready = 0;
        wr_reg(REG_CTRL, 32'h8);
        check("abort_idle_lit", dma_busy, 0);
        rd_reg(REG_STAT, v); check("abort_status_lit", v, 32'h0003_0004);
        so_mode = 0;

        // address wrap from 0x3FFF
        wr_reg(REG_STAT, 32'h6);
        wr_reg(REG_ADDR, 32'h0000_FFFC);
        wr_reg(REG_LEN, 32'h2);
        si_q.delete(); si_q.push_back(16'h5A5A); si_q.push_back(16'hA5A5);
        wr_adr_log.delete();
        wr_reg(REG_CTRL, 32'h3);
        wait_idle(200);
        check("wrap_ram", {ram[14'h3FFF], ram[14'h0000]}, 32'h5A5A_A5A5);
        if (wr_adr_log.size() == 2) check("wrap_adr1", wr_adr_log[1], 14'h0000);
        else check("wrap_count", wr_adr_log.size(), 2);

        // interrupt
        wr_reg(REG_STAT, 32'h2);
        wr_reg(REG_ADDR, 32'h0000_0100);
        wr_reg(REG_LEN, 32'h1);
        wr_reg(REG_CTRL, 32'h5);
        wait_idle(100);
        repeat (2) @(negedge clk);
`ifdef DMA_IRQ_EN
        check("irq_raised_lit", dma_irq, 1);
`else
        check("irq_absent_lit", dma_irq, 0);
        rd_reg(REG_CTRL, v); check("irq_en_reads0_lit", v, 32'h0);
`endif
        wr_reg(REG_STAT, 32'h2);
        repeat (2) @(negedge clk);
        check("irq_cleared_lit", dma_irq, 0);
        wr_reg(REG_CTRL, 32'h0);

        // randomized transfers
        for (int t = 0; t < 30; t++) begin
            so_pct   = 30 + $urandom_range(70);
            si_pct   = 30 + $urandom_range(70);
            hold_pct = $urandom_range(40);
            len      = $urandom_range(6);
            wr_reg(REG_STAT, 32'h6);
            if ($urandom_range(3) == 0) v = 32'(14'h3FFC + 14'($urandom_range(3))) << 2;
            else v = 32'($urandom_range(16383)) << 2;
            wr_reg(REG_ADDR, v);
            wr_reg(REG_LEN, 32'(len));
            si_q.delete();
            for (int k = 0; k < len; k++) si_q.push_back(16'($urandom));
            wr_reg(REG_CTRL, {28'd0, 1'b0, 1'b0, 1'($urandom_range(1)), 1'b1});
            if ($urandom_range(4) == 0) begin
                repeat ($urandom_range(10)) @(posedge clk);
                wr_reg(REG_CTRL, 32'h8);
            end
            wait_idle(600);
            si_q.delete();
        end
        hold_pct = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_mem_engine.md
Name: dma_mem_engine

Overview:
- DMA controller at the far end of the MA-stage DMA/IO interface.
- Acts as the IO-space register responder for CPU loads and stores to addresses with bits [31:30]=2'b11.
- Acts as the initiator on the 16-bit data-RAM DMA port.
- Moves 16-bit items between data RAM and an external valid/ready stream, in either direction, one word address per item.

Parameters:
- REG_BASE, 14'h3C00, word address [15:2] of register 0; registers occupy REG_BASE+0..3.
- AWIDTH, 14, width of the data-RAM word address driven on dataram_*_ma.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dma_io_we  in  1  CPU IO store strobe (full-word stores only)
- dma_io_wadr  in  14  IO store word address [15:2]
- dma_io_wdata  in  32  IO store data
- dma_io_radr  in  14  IO load word address [15:2]
- dma_io_rdata  out  32  registered read data, valid the cycle after dma_io_radr
- mem_hold  in  1  higher-priority RAM user active (d_read_sel | d_ram_wen); no request may be issued this cycle
- dma_we_ma  out  1  data-RAM write request
- dataram_wadr_ma  out  AWIDTH  write word address
- dataram_wdata_ma  out  16  write data
- dma_re_ma  out  1  data-RAM read request
- dataram_radr_ma  out  AWIDTH  read word address
- dataram_rdata_wb  in  16  read data, one cycle after dma_re_ma
- so_valid / so_data[15:0] out, so_ready in  stream out (mem->stream)
- si_valid / si_data[15:0] in, si_ready out  stream in (stream->mem)
- dma_busy  out  1  engine active; pipeline must stall CPU data-RAM accesses
- dma_irq  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Registers, at word offsets from REG_BASE:
  - +0 CTRL: bit0 START (W1, self-clearing), bit1 DIR (0 = mem->stream, 1 = stream->mem), bit2 IRQ_EN, bit3 ABORT (W1).
  - +1 ADDR: bits [15:2] are the start word address.
  - +2 LEN: bits [15:0] give the 16-bit item count.
  - +3 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 ABORTED (sticky, W1C), bits [31:16] remaining count (RO).
- Register access:
  - Reads of unmapped offsets return 0; dma_io_rdata is registered every cycle.
  - Writes to ADDR/LEN while busy are ignored; START while busy is ignored.
- Reset: all outputs 0; registers 0; state IDLE.
- State machine: IDLE, RD_REQ, RD_DATA, OUT, IN, WR.
  - IDLE, on START: load cur_addr=ADDR and rem=LEN.
    - rem==0: set DONE the next cycle and stay IDLE.
    - Otherwise go to RD_REQ (DIR=0) or IN (DIR=1).
  - RD_REQ: drive dma_re_ma=1 with dataram_radr_ma=cur_addr when mem_hold=0, then go to RD_DATA. If mem_hold=1, hold with dma_re_ma=0.
  - RD_DATA: capture dataram_rdata_wb into the output buffer, then go to OUT.
  - OUT: so_valid=1 and so_data stable until so_ready. On handshake: cur_addr+1 (wraps mod 2^AWIDTH), rem-1. If rem becomes 0, set DONE and go to IDLE; otherwise go to RD_REQ.
  - IN: si_ready=1. On si_valid capture si_data and go to WR.
  - WR: dma_we_ma=1 for exactly one cycle when mem_hold=0, with dataram_wadr_ma=cur_addr and dataram_wdata_ma=captured data. Then cur_addr+1, rem-1, and go to IN, or to IDLE with DONE when rem reaches 0.
- Throughput: mem->stream takes 3 cycles per item minimum; stream->mem takes 2.
- ABORT in any state: go to IDLE next cycle, drop any pending request, set ABORTED, leave DONE clear. An already-issued read is discarded.
- Simultaneous CPU W1C of DONE and hardware set of DONE in the same cycle: the set wins.
- dma_busy = (state != IDLE).
- Address and data outputs are held at their last value when the request strobe is low.

Optional Feature:
- Macro DMA_IRQ_EN.
- Defined: dma_irq = DONE & IRQ_EN, registered; it clears when DONE is cleared.
- Undefined: dma_irq is tied to 0, IRQ_EN reads back 0, and the interrupt logic is absent.

Decomposition:
- Package dma_pkg holds the register offsets (REG_CTRL=0, REG_ADDR=1, REG_LEN=2, REG_STAT=3), the CTRL/STATUS bit positions, and the state encoding.
- One sub-module, dma_io_regs: register decode, read mux, W1/W1C logic and rdata flop. It exports start/abort pulses and config to the FSM and takes busy/done/rem back.

Test Plan:
- Register I/O: write ADDR=0x0100, LEN=3, then read back → dma_io_rdata = 0x00000100 and 0x00000003 one cycle after each read address; an unmapped offset +5 reads 0.
- mem->stream: RAM words 0x40..0x42 hold 0x1111/0x2222/0x3333; START with DIR=0; so_ready toggles 1,0,1 → so_data sequence is 1111, 2222, 3333. Then DONE=1, BUSY=0 and rem=0.
- stream->mem: DIR=1, ADDR word 0x80, LEN=2; send 0xAAAA then 0xBBBB → dma_we_ma pulses at 0x80 and 0x81 with that data; DONE is set after the second write.
- mem_hold held high for 4 cycles during RD_REQ/WR → no dma_re_ma/dma_we_ma asserted while high; the request issues the cycle after hold drops and the data is unchanged.
- LEN=0 START → DONE set, no memory strobe; START while busy → ignored, rem unchanged; wrap from ADDR=0x3FFF with LEN=2 → second access at 0x0000.
- ABORT mid-transfer (after item 1 of 4) → IDLE next cycle, ABORTED=1, DONE=0, rem=3. With DMA_IRQ_EN and IRQ_EN=1, a normal completion raises dma_irq, and a W1C of DONE drops it.
